// File: rtl/mbist_resp_checker.sv
// MBIST read-side response checker: re-encodes read data into a background code,
// compares it with the expected code, and keeps fail / count / first-failure results per run.
module mbist_resp_checker #(
  parameter int ADDR_W = 4,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              done,
  input  logic              chk_valid,
  input  logic [ADDR_W-1:0] chk_addr,
  input  logic [2:0]        q,
  input  logic [7:0]        data_r,
  output logic              err_pulse,
  output logic [2:0]        obs_code,
  output logic              fail,
  output logic [CNT_W-1:0]  err_count,
  output logic [ADDR_W-1:0] first_addr,
  output logic [7:0]        first_data,
  output logic [2:0]        first_q,
  output logic              busy,
  output logic              result_valid
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]        state;
  logic              drain_cnt;
  logic              accept;
  logic              s1_valid;
  logic [ADDR_W-1:0] s1_addr;
  logic [2:0]        s1_q;
  logic [7:0]        s1_data;
  logic [2:0]        enc;
  logic              mismatch;

  // A sample arriving together with start is dropped so the new run begins clean.
  assign accept = chk_valid && (state == RUN) && !start;

  always_comb begin
    case (s1_data)
      8'hAA:   enc = 3'd0;
      8'h55:   enc = 3'd1;
      8'hF0:   enc = 3'd2;
      8'h0F:   enc = 3'd3;
      8'h00:   enc = 3'd4;
      8'hFF:   enc = 3'd5;
      default: enc = 3'b111;
    endcase
  end

  assign mismatch = (s1_q > 3'd5) || (enc != s1_q);

  // DRAIN holds for two cycles, which is exactly the time the pipeline needs to empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      drain_cnt <= 1'b0;
    end else if (start) begin
      state     <= RUN;
      drain_cnt <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (done) begin
            state     <= DRAIN;
            drain_cnt <= 1'b0;
          end
        end
        DRAIN: begin
          if (drain_cnt) state <= DONE;
          else           drain_cnt <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_addr  <= '0;
      s1_q     <= '0;
      s1_data  <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_addr <= chk_addr;
        s1_q    <= q;
        s1_data <= data_r;
      end
    end
  end

  // First-failure fields are captured only while fail is still clear for this run.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_pulse  <= 1'b0;
      obs_code   <= 3'b111;
      fail       <= 1'b0;
      err_count  <= '0;
      first_addr <= '0;
      first_data <= '0;
      first_q    <= '0;
    end else if (start) begin
      err_pulse  <= 1'b0;
      obs_code   <= 3'b111;
      fail       <= 1'b0;
      err_count  <= '0;
      first_addr <= '0;
      first_data <= '0;
      first_q    <= '0;
    end else begin
      err_pulse <= s1_valid && mismatch;
      if (s1_valid) begin
        obs_code <= enc;
        if (mismatch) begin
          fail <= 1'b1;
          if (err_count != {CNT_W{1'b1}})
            err_count <= err_count + {{(CNT_W-1){1'b0}}, 1'b1};
          if (!fail) begin
            first_addr <= s1_addr;
            first_data <= s1_data;
            first_q    <= s1_q;
          end
        end
      end
    end
  end

  assign busy         = (state == RUN) || (state == DRAIN);
  assign result_valid = (state == DONE);

endmodule

// File: tb/tb_mbist_resp_checker.sv
// Bench for mbist_resp_checker: directed scenarios plus random runs, checked every cycle
// against a queue-based run model; a second instance with CNT_W=2 exercises saturation.
module tb_mbist_resp_checker;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_DRAIN = 2;
  localparam int M_DONE  = 3;
  localparam logic [7:0] PAT [6] = '{8'hAA, 8'h55, 8'hF0, 8'h0F, 8'h00, 8'hFF};

  typedef struct {
    logic [3:0] a;
    logic [2:0] q;
    logic [7:0] d;
  } samp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0, done = 1'b0, chk_valid = 1'b0;
  logic [3:0] chk_addr = '0;
  logic [2:0] q = '0;
  logic [7:0] data_r = '0;

  logic       a_err_pulse, a_fail, a_busy, a_result_valid;
  logic [2:0] a_obs_code, a_first_q;
  logic [7:0] a_err_count, a_first_data;
  logic [3:0] a_first_addr;
  logic       b_err_pulse, b_fail, b_busy, b_result_valid;
  logic [2:0] b_obs_code, b_first_q;
  logic [1:0] b_err_count;
  logic [7:0] b_first_data;
  logic [3:0] b_first_addr;

  int compared = 0;
  int mismatched = 0;

  int         m_state = M_IDLE;
  int         m_drain = 0;
  int         m_cnt = 0;
  logic       m_pulse = 1'b0;
  logic [2:0] m_obs = 3'b111;
  logic [3:0] m_faddr = '0;
  logic [7:0] m_fdata = '0;
  logic [2:0] m_fq = '0;
  samp_t      pend[$];
  samp_t      m_s;

  mbist_resp_checker #(.ADDR_W(4), .CNT_W(8)) dut_a (
    .clk(clk), .rst(rst), .start(start), .done(done), .chk_valid(chk_valid),
    .chk_addr(chk_addr), .q(q), .data_r(data_r),
    .err_pulse(a_err_pulse), .obs_code(a_obs_code), .fail(a_fail),
    .err_count(a_err_count), .first_addr(a_first_addr), .first_data(a_first_data),
    .first_q(a_first_q), .busy(a_busy), .result_valid(a_result_valid)
  );

  mbist_resp_checker #(.ADDR_W(4), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .start(start), .done(done), .chk_valid(chk_valid),
    .chk_addr(chk_addr), .q(q), .data_r(data_r),
    .err_pulse(b_err_pulse), .obs_code(b_obs_code), .fail(b_fail),
    .err_count(b_err_count), .first_addr(b_first_addr), .first_data(b_first_data),
    .first_q(b_first_q), .busy(b_busy), .result_valid(b_result_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] encode(input logic [7:0] d);
    for (int i = 0; i < 6; i++)
      if (PAT[i] == d) return 3'(i);
    return 3'b111;
  endfunction

  function automatic int sat(input int n, input int maxv);
    return (n > maxv) ? maxv : n;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic st, input logic dn, input logic v,
                               input logic [3:0] a, input logic [2:0] qq, input logic [7:0] d);
    start = st; done = dn; chk_valid = v; chk_addr = a; q = qq; data_r = d;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 4'd0, 3'd0, 8'h00);
  endtask

  // Run-level model: samples accepted in RUN take effect one edge later; results are
  // derived from the total failure count and the first failing sample of the run.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_state = M_IDLE; m_drain = 0; m_cnt = 0; m_pulse = 0; m_obs = 3'b111;
      m_faddr = '0; m_fdata = '0; m_fq = '0;
      pend.delete();
    end else if (start) begin
      m_state = M_RUN; m_drain = 0; m_cnt = 0; m_pulse = 0; m_obs = 3'b111;
      m_faddr = '0; m_fdata = '0; m_fq = '0;
      pend.delete();
    end else begin
      m_pulse = 0;
      while (pend.size() > 0) begin
        m_s = pend.pop_front();
        m_obs = encode(m_s.d);
        if (m_s.q > 3'd5 || m_obs != m_s.q) begin
          m_pulse = 1;
          if (m_cnt == 0) begin
            m_faddr = m_s.a; m_fdata = m_s.d; m_fq = m_s.q;
          end
          m_cnt++;
        end
      end
      if (m_state == M_RUN) begin
        if (chk_valid) pend.push_back('{chk_addr, q, data_r});
        if (done) begin m_state = M_DRAIN; m_drain = 2; end
      end else if (m_state == M_DRAIN) begin
        m_drain--;
        if (m_drain == 0) m_state = M_DONE;
      end
    end
  end

  always @(negedge clk) begin
    checkOutput("a_err_pulse", 32'(a_err_pulse), 32'(m_pulse));
    checkOutput("a_obs_code", 32'(a_obs_code), 32'(m_obs));
    checkOutput("a_fail", 32'(a_fail), 32'(m_cnt > 0));
    checkOutput("a_err_count", 32'(a_err_count), 32'(sat(m_cnt, 255)));
    checkOutput("a_first_addr", 32'(a_first_addr), 32'(m_faddr));
    checkOutput("a_first_data", 32'(a_first_data), 32'(m_fdata));
    checkOutput("a_first_q", 32'(a_first_q), 32'(m_fq));
    checkOutput("a_busy", 32'(a_busy), 32'(m_state == M_RUN || m_state == M_DRAIN));
    checkOutput("a_result_valid", 32'(a_result_valid), 32'(m_state == M_DONE));
    checkOutput("b_err_count", 32'(b_err_count), 32'(sat(m_cnt, 3)));
    checkOutput("b_fail", 32'(b_fail), 32'(m_cnt > 0));
    checkOutput("b_err_pulse", 32'(b_err_pulse), 32'(m_pulse));
  end

  initial begin
    int pick;
    logic [2:0] rq;
    logic [7:0] rd;

    #1 rst = 1'b1;
    @(negedge clk);
    checkOutput("lit_reset_obs", 32'(a_obs_code), 32'h7);
    checkOutput("lit_reset_busy", 32'(a_busy), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    idle(2);

    $display("[TB] clean run");
    applyStimulus(1, 0, 0, 4'd0, 3'd0, 8'h00);
    for (int i = 0; i < 16; i++) applyStimulus(0, 0, 1, 4'(i), 3'd0, 8'hAA);
    applyStimulus(0, 1, 0, 4'd0, 3'd0, 8'h00);
    idle(1);
    checkOutput("lit_clean_rv_early", 32'(a_result_valid), 32'h0);
    idle(1);
    checkOutput("lit_clean_rv", 32'(a_result_valid), 32'h1);
    checkOutput("lit_clean_obs", 32'(a_obs_code), 32'h0);
    checkOutput("lit_clean_cnt", 32'(a_err_count), 32'h0);
    checkOutput("lit_clean_fail", 32'(a_fail), 32'h0);

    $display("[TB] single fault");
    applyStimulus(1, 0, 0, 4'd0, 3'd0, 8'h00);
    for (int i = 0; i < 16; i++) begin
      applyStimulus(0, 0, 1, 4'(i), 3'd2, (i == 5) ? 8'hF1 : 8'hF0);
      if (i == 5) checkOutput("lit_sf_pulse_early", 32'(a_err_pulse), 32'h0);
      if (i == 6) begin
        checkOutput("lit_sf_pulse", 32'(a_err_pulse), 32'h1);
        checkOutput("lit_sf_obs", 32'(a_obs_code), 32'h7);
      end
    end
    applyStimulus(0, 1, 0, 4'd0, 3'd0, 8'h00);
    idle(3);
    checkOutput("lit_sf_cnt", 32'(a_err_count), 32'h1);
    checkOutput("lit_sf_faddr", 32'(a_first_addr), 32'h5);
    checkOutput("lit_sf_fdata", 32'(a_first_data), 32'hF1);
    checkOutput("lit_sf_fq", 32'(a_first_q), 32'h2);

    $display("[TB] multiple faults");
    applyStimulus(1, 0, 0, 4'd0, 3'd0, 8'h00);
    for (int i = 0; i < 16; i++) begin
      applyStimulus(0, 0, 1, 4'(i), 3'd1, (i == 3) ? 8'h0F : (i == 9) ? 8'h12 : 8'h55);
      if (i == 4) checkOutput("lit_mf_obs3", 32'(a_obs_code), 32'h3);
    end
    applyStimulus(0, 1, 0, 4'd0, 3'd0, 8'h00);
    idle(3);
    checkOutput("lit_mf_cnt", 32'(a_err_count), 32'h2);
    checkOutput("lit_mf_faddr", 32'(a_first_addr), 32'h3);
    checkOutput("lit_mf_fdata", 32'(a_first_data), 32'h0F);
    checkOutput("lit_mf_fq", 32'(a_first_q), 32'h1);

    $display("[TB] saturation");
    applyStimulus(1, 0, 0, 4'd0, 3'd0, 8'h00);
    for (int j = 0; j < 7; j++) begin
      applyStimulus(0, 0, (j < 6), 4'(j), 3'd0, 8'h55);
      if (j >= 1) checkOutput("lit_sat_cnt", 32'(b_err_count), 32'(sat(j, 3)));
    end
    checkOutput("lit_sat_fail", 32'(b_fail), 32'h1);
    checkOutput("lit_sat_cnt_a", 32'(a_err_count), 32'h6);

    $display("[TB] illegal expectation");
    applyStimulus(1, 0, 0, 4'd0, 3'd0, 8'h00);
    applyStimulus(0, 0, 1, 4'd7, 3'd6, 8'h00);
    idle(1);
    checkOutput("lit_ill_obs", 32'(a_obs_code), 32'h4);
    checkOutput("lit_ill_fq", 32'(a_first_q), 32'h6);
    checkOutput("lit_ill_fail", 32'(a_fail), 32'h1);

    $display("[TB] restart mid-run");
    applyStimulus(1, 0, 0, 4'd0, 3'd0, 8'h00);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 4'(i), 3'd0, 8'h12);
    checkOutput("lit_rs_before", 32'(a_err_count), 32'h2);
    applyStimulus(1, 0, 1, 4'd3, 3'd0, 8'h12);
    checkOutput("lit_rs_cleared", 32'(a_err_count), 32'h0);
    idle(2);
    checkOutput("lit_rs_dropped", 32'(a_err_count), 32'h0);
    checkOutput("lit_rs_obs", 32'(a_obs_code), 32'h7);

    $display("[TB] done with sample");
    applyStimulus(0, 0, 1, 4'd0, 3'd0, 8'hAA);
    applyStimulus(0, 1, 1, 4'd1, 3'd0, 8'h34);
    idle(2);
    checkOutput("lit_dv_cnt", 32'(a_err_count), 32'h1);
    checkOutput("lit_dv_faddr", 32'(a_first_addr), 32'h1);
    checkOutput("lit_dv_rv", 32'(a_result_valid), 32'h1);

    $display("[TB] reset in drain");
    applyStimulus(1, 0, 0, 4'd0, 3'd0, 8'h00);
    applyStimulus(0, 0, 1, 4'd2, 3'd3, 8'h99);
    applyStimulus(0, 1, 0, 4'd0, 3'd0, 8'h00);
    checkOutput("lit_rd_busy_pre", 32'(a_busy), 32'h1);
    checkOutput("lit_rd_cnt_pre", 32'(a_err_count), 32'h1);
    #2 rst = 1'b1;
    #1;
    checkOutput("lit_rd_obs", 32'(a_obs_code), 32'h7);
    checkOutput("lit_rd_cnt", 32'(a_err_count), 32'h0);
    checkOutput("lit_rd_fail", 32'(a_fail), 32'h0);
    checkOutput("lit_rd_busy", 32'(a_busy), 32'h0);
    checkOutput("lit_rd_faddr", 32'(a_first_addr), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    idle(2);

    $display("[TB] random runs");
    for (int c = 0; c < 3000; c++) begin
      rq = 3'($urandom_range(0, 7));
      pick = $urandom_range(0, 3);
      if (pick == 0)      rd = 8'($urandom);
      else if (pick == 1) rd = PAT[$urandom_range(0, 5)];
      else                rd = (rq < 3'd6) ? PAT[rq] : 8'h00;
      applyStimulus(($urandom_range(0, 59) == 0), ($urandom_range(0, 29) == 0),
                    ($urandom_range(0, 3) != 0), 4'($urandom), rq, rd);
      if (c % 700 == 350) begin
        #2 rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end
    end
    idle(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/mbist_resp_checker.md
Name: mbist_resp_checker

Overview:
- Read-side counterpart of the MBIST data-background decoder: takes memory read data and the background code the controller expected, then encodes the read word back into a 3-bit background code.
- Compares observed against expected data; counts failures; logs the first failing address/data/code.
- Sits between the memory read port and the MBIST controller. A run is bracketed by start/done, and the result is reported via a DONE state.

Parameters:
- ADDR_W, 4, width of memory address under test
- CNT_W, 8, width of saturating error counter

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse: clear results, begin run
- done  in  1  one-cycle pulse from controller: last read issued
- chk_valid  in  1  read sample valid this cycle
- chk_addr  in  ADDR_W  address of the read sample
- q  in  3  expected background code (0..5 legal)
- data_r  in  8  memory read data
- err_pulse  out  1  one-cycle pulse per failing sample
- obs_code  out  3  encoded code of last checked sample (3'b111 = no pattern match)
- fail  out  1  sticky, set on any failure in the current run
- err_count  out  CNT_W  failures in the current run, saturating
- first_addr  out  ADDR_W  address of first failure
- first_data  out  8  read data of first failure
- first_q  out  3  expected code of first failure
- busy  out  1  high in RUN and DRAIN
- result_valid  out  1  high in DONE; results stable

Behaviour:
- Reset (async, rst=1): state IDLE; all outputs 0 except obs_code=3'b111. Pipeline valid bits are cleared.
- Encoding (combinational on the stage-1 data):
  - 8'hAA->0, 8'h55->1, 8'hF0->2, 8'h0F->3, 8'h00->4, 8'hFF->5.
  - Any other value->3'b111.
- Failure condition for a sample:
  - q is 6 or 7 (illegal expectation), or
  - encoded code != q.
- Pipeline, 2 stages:
  - Cycle N: chk_valid is sampled; addr, q and data_r are registered into stage 1.
  - Cycle N+1: encode/compare is registered into stage 2. err_pulse, obs_code, fail, err_count and first_* update at the same edge.
  - Latency from chk_valid to err_pulse is 2 clocks. One sample per clock is sustained.
- obs_code updates on every checked sample, pass or fail. It holds otherwise.
- err_count increments by 1 per failing sample and saturates at 2^CNT_W-1 (no wrap). fail remains set.
- first_* latch only on the first failure of a run, i.e. when fail was 0 before that edge. They hold afterwards.
- FSM:
  - IDLE: start->RUN. chk_valid and done are ignored.
  - RUN: chk_valid accepted. done->DRAIN.
  - DRAIN: no new samples accepted. After 2 cycles (pipeline empty)->DONE.
  - DONE: result_valid=1. start->RUN. chk_valid and done are ignored.
- start in any state:
  - In the same cycle: clears fail, err_count, first_*, pipeline valid bits and obs_code (to 3'b111); goes to RUN.
  - A chk_valid in the same cycle as start is dropped.
  - In RUN or DRAIN, start aborts the run and restarts it.
- done and chk_valid in the same cycle in RUN: the sample is accepted, then the FSM enters DRAIN.
- done and start in the same cycle: start wins.
- done outside RUN is ignored.
- rst during any state aborts immediately. Nothing is preserved.

Test Plan:
- Clean run: start; 16 samples addr 0..15, q=0, data_r=8'hAA; done -> err_pulse never asserted; obs_code=0; fail=0; err_count=0; result_valid 3 cycles after done.
- Single fault: q=2, data_r=8'hF0 everywhere except addr 5 with data_r=8'hF1 -> one err_pulse, 2 clocks after the addr-5 chk_valid; obs_code=7; err_count=1; first_addr=5; first_data=8'hF1; first_q=2.
- Multiple faults: failures at addr 3 (data 8'h0F, q=1) then addr 9 -> err_count=2; first_addr=3; first_data=8'h0F; first_q=1; obs_code after addr 3 =3.
- Saturation with CNT_W=2: 6 consecutive failing samples -> err_count 1,2,3,3,3,3; fail=1.
- Illegal expectation: q=6, data_r=8'h00 -> failure; obs_code=4; first_q=6.
- Control corners:
  - start asserted mid-RUN after 2 failures -> counters clear; the same-cycle sample is dropped.
  - done with chk_valid in the same cycle -> that sample is counted.
  - rst asserted in DRAIN -> all outputs return to reset values immediately; obs_code=7.
